// File: rtl/imm_gen_pkg.sv
// Shared select codes and parameter checks for the pipelined immediate generator.
package imm_gen_pkg;

   localparam logic [2:0] SEL_I   = 3'b000;
   localparam logic [2:0] SEL_S   = 3'b001;
   localparam logic [2:0] SEL_B   = 3'b010;
   localparam logic [2:0] SEL_U   = 3'b011;
   localparam logic [2:0] SEL_J   = 3'b100;
   localparam logic [2:0] SEL_Z   = 3'b101;
   localparam logic [2:0] SEL_SH  = 3'b110;
   localparam logic [2:0] SEL_ILL = 3'b111;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decode from instruction bits [31:7]; instr[k] holds bit k+7.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [24:0]     instr,
   input  logic [2:0]      sel,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   logic [31:0] v32;
   logic        sext;

   // Every mode is first formed as a 32-bit value, then widened signed or unsigned.
   always_comb begin
      v32     = '0;
      sext    = 1'b1;
      illegal = 1'b0;
      case (sel)
         SEL_I:  v32 = {{20{instr[24]}}, instr[24:13]};
         SEL_S:  v32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
         SEL_B:  v32 = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
         SEL_U:  v32 = {instr[24:5], 12'b0};
         SEL_J:  v32 = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
         SEL_Z: begin
            v32  = {27'b0, instr[12:8]};
            sext = 1'b0;
         end
         SEL_SH: begin
            v32  = (XLEN == 64) ? {26'b0, instr[18:13]} : {27'b0, instr[17:13]};
            sext = 1'b0;
         end
         default: begin
            v32     = '0;
            sext    = 1'b0;
            illegal = 1'b1;
         end
      endcase
   end

   assign imm = sext ? XLEN'($signed(v32)) : XLEN'(v32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator stage: decode on input, main output register plus one skid register.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      in_instr,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   logic [XLEN-1:0]  dec_imm;
   logic             dec_illegal;

   logic             main_valid;
   logic [XLEN-1:0]  main_imm;
   logic             main_illegal;
   logic [TAG_W-1:0] main_tag;

   logic             skid_valid;
   logic [XLEN-1:0]  skid_imm;
   logic             skid_illegal;
   logic [TAG_W-1:0] skid_tag;

   logic             accept;
   logic             main_free;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr   (in_instr),
      .sel     (in_sel),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   assign in_ready  = !skid_valid;
   assign accept    = in_valid && in_ready;
   assign main_free = !main_valid || out_ready;

   // A full skid implies in_ready is low, so a refill from skid never coincides with an accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid   <= 1'b0;
         main_imm     <= '0;
         main_illegal <= 1'b0;
         main_tag     <= '0;
         skid_valid   <= 1'b0;
         skid_imm     <= '0;
         skid_illegal <= 1'b0;
         skid_tag     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         if (skid_valid) begin
            main_valid   <= 1'b1;
            main_imm     <= skid_imm;
            main_illegal <= skid_illegal;
            main_tag     <= skid_tag;
            skid_valid   <= 1'b0;
         end else begin
            main_valid <= accept;
            if (accept) begin
               main_imm     <= dec_imm;
               main_illegal <= dec_illegal;
               main_tag     <= in_tag;
            end
         end
      end else if (accept) begin
         skid_valid   <= 1'b1;
         skid_imm     <= dec_imm;
         skid_illegal <= dec_illegal;
         skid_tag     <= in_tag;
      end
   end

   assign out_valid   = main_valid;
   assign out_imm     = main_imm;
   assign out_illegal = main_illegal;
   assign out_tag     = main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench driving an XLEN=32 and an XLEN=64 instance with identical stimulus.
module tb_imm_gen_pipe;

   localparam int TAG_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic [24:0]      in_instr;
   logic [2:0]       in_sel;
   logic [TAG_W-1:0] in_tag;
   logic             out_ready;

   logic             rdy32, vld32, ill32;
   logic [31:0]      imm32;
   logic [TAG_W-1:0] tag32;
   logic             rdy64, vld64, ill64;
   logic [63:0]      imm64;
   logic [TAG_W-1:0] tag64;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(vld32),
      .out_ready(out_ready), .out_imm(imm32), .out_illegal(ill32), .out_tag(tag32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(vld64),
      .out_ready(out_ready), .out_imm(imm64), .out_illegal(ill64), .out_tag(tag64)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] instr, input logic [2:0] sel, input logic [TAG_W-1:0] tag);
      in_valid = 1'b1;
      in_instr = instr[31:7];
      in_sel   = sel;
      in_tag   = tag;
   endtask

   task automatic beat(input logic [31:0] instr, input logic [2:0] sel, input logic [TAG_W-1:0] tag);
      present(instr, sel, tag);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      present(32'hFFF00093, 3'b000, 8'hAA);
      tick();
      tick();
      checks++;
      if ({vld32, vld64} !== 2'b00) begin
         errors++; $display("FAIL reset_valid got %b want 00", {vld32, vld64});
      end
      checks++;
      if ({imm32, imm64, ill32, ill64, tag32, tag64} !== '0) begin
         errors++; $display("FAIL reset_data got %h/%h ill %b%b tag %h/%h want all zero",
                            imm32, imm64, ill32, ill64, tag32, tag64);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({rdy32, rdy64} !== 2'b11) begin
         errors++; $display("FAIL reset_ready got %b want 11", {rdy32, rdy64});
      end
   endtask

   task automatic test_modes();
      logic [31:0] t_instr [9] = '{32'h00500093, 32'hFFF00093, 32'h00208463, 32'hFE000EE3,
                                   32'h008000EF, 32'h80000037, 32'h000FD073, 32'h03F01013,
                                   32'h12345678};
      logic [2:0]  t_sel   [9] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6, 3'd7};
      logic [31:0] t_e32   [9] = '{32'h5, 32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'h8,
                                   32'h80000000, 32'h1F, 32'h1F, 32'h0};
      logic [63:0] t_e64   [9] = '{64'h5, 64'hFFFFFFFFFFFFFFFF, 64'h8, 64'hFFFFFFFFFFFFFFFC, 64'h8,
                                   64'hFFFFFFFF80000000, 64'h1F, 64'h3F, 64'h0};
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         beat(t_instr[i], t_sel[i], TAG_W'(8'h40 + i));
         checks++;
         if ({vld32, vld64} !== 2'b11) begin
            errors++; $display("FAIL mode%0d_valid got %b want 11", i, {vld32, vld64});
         end
         checks++;
         if (imm32 !== t_e32[i]) begin
            errors++; $display("FAIL mode%0d_imm32 got %h want %h", i, imm32, t_e32[i]);
         end
         checks++;
         if (imm64 !== t_e64[i]) begin
            errors++; $display("FAIL mode%0d_imm64 got %h want %h", i, imm64, t_e64[i]);
         end
         checks++;
         if ({ill32, ill64} !== {2{t_sel[i] == 3'd7}}) begin
            errors++; $display("FAIL mode%0d_illegal got %b want %b", i, {ill32, ill64}, {2{t_sel[i] == 3'd7}});
         end
         checks++;
         if (tag32 !== TAG_W'(8'h40 + i) || tag64 !== TAG_W'(8'h40 + i)) begin
            errors++; $display("FAIL mode%0d_tag got %h/%h want %h", i, tag32, tag64, 8'h40 + i);
         end
      end
      tick();
      checks++;
      if ({vld32, vld64} !== 2'b00) begin
         errors++; $display("FAIL modes_drain got %b want 00", {vld32, vld64});
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         present(32'h00100093 + (32'(k) << 20), 3'd0, TAG_W'(10 + k));
         tick();
         checks++;
         if (vld32 !== 1'b1 || tag32 !== TAG_W'(10 + k) || imm32 !== 32'(1 + k) || rdy32 !== 1'b1) begin
            errors++; $display("FAIL b2b%0d got v%b tag %0d imm %0d rdy %b want v1 tag %0d imm %0d rdy 1",
                               k, vld32, tag32, imm32, rdy32, 10 + k, 1 + k);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      logic [TAG_W-1:0] want;
      out_ready = 1'b0;
      beat(32'h00100093, 3'd0, 8'd1);
      checks++;
      if (rdy32 !== 1'b1 || tag32 !== 8'd1 || vld32 !== 1'b1) begin
         errors++; $display("FAIL bp_first got rdy %b v %b tag %0d want rdy 1 v 1 tag 1", rdy32, vld32, tag32);
      end
      beat(32'h00200093, 3'd0, 8'd2);
      checks++;
      if ({rdy32, rdy64} !== 2'b00) begin
         errors++; $display("FAIL bp_ready_drop got %b want 00", {rdy32, rdy64});
      end
      present(32'h00300093, 3'd0, 8'd3);
      tick();
      checks++;
      if (rdy32 !== 1'b0 || vld32 !== 1'b1 || tag32 !== 8'd1 || imm32 !== 32'd1 || tag64 !== 8'd1) begin
         errors++; $display("FAIL bp_hold got rdy %b v %b tag %0d imm %0d want rdy 0 v 1 tag 1 imm 1",
                            rdy32, vld32, tag32, imm32);
      end
      out_ready = 1'b1;
      for (int k = 2; k <= 3; k++) begin
         tick();
         want = TAG_W'(k);
         checks++;
         if (vld32 !== 1'b1 || tag32 !== want || imm32 !== 32'(k) || tag64 !== want) begin
            errors++; $display("FAIL bp_order%0d got v %b tag %0d/%0d imm %0d want v 1 tag %0d",
                               k, vld32, tag32, tag64, imm32, k);
         end
         if (k == 2) begin
            checks++;
            if (rdy32 !== 1'b1) begin
               errors++; $display("FAIL bp_ready_rise got %b want 1", rdy32);
            end
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if ({vld32, vld64} !== 2'b00) begin
         errors++; $display("FAIL bp_no_dup got %b want 00", {vld32, vld64});
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      beat(32'h00400093, 3'd0, 8'd4);
      beat(32'h00500093, 3'd0, 8'd5);
      present(32'h00600093, 3'd0, 8'd6);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({vld32, vld64, rdy32, rdy64} !== 4'b0011) begin
         errors++; $display("FAIL flush_full got v %b%b rdy %b%b want v 00 rdy 11", vld32, vld64, rdy32, rdy64);
      end
      beat(32'h00700093, 3'd0, 8'd7);
      present(32'h00800093, 3'd0, 8'd8);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({vld32, vld64, rdy32} !== 3'b001) begin
         errors++; $display("FAIL flush_inbound got v %b%b rdy %b want v 00 rdy 1", vld32, vld64, rdy32);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if ({vld32, vld64} !== 2'b00) begin
         errors++; $display("FAIL flush_dropped got v %b%b tag %0d want v 00", vld32, vld64, tag32);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      beat(32'hFFF00093, 3'd0, 8'h21);
      beat(32'hFFF00093, 3'd7, 8'h22);
      checks++;
      if (rdy32 !== 1'b0) begin
         errors++; $display("FAIL rmid_full got rdy %b want 0", rdy32);
      end
      present(32'hFFF00093, 3'd0, 8'h23);
      rst   = 1'b1;
      flush = 1'b1;
      tick();
      rst   = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({vld32, vld64, ill32, ill64} !== 4'b0000 || imm32 !== '0 || imm64 !== '0 ||
          tag32 !== '0 || tag64 !== '0 || {rdy32, rdy64} !== 2'b11) begin
         errors++; $display("FAIL rmid_clear got v %b%b imm %h/%h ill %b%b tag %h/%h rdy %b%b want zeros rdy 11",
                            vld32, vld64, imm32, imm64, ill32, ill64, tag32, tag64, rdy32, rdy64);
      end
      out_ready = 1'b1;
      beat(32'h00112223, 3'd1, 8'h30);
      checks++;
      if (vld32 !== 1'b1 || imm32 !== 32'h4 || imm64 !== 64'h4 || tag32 !== 8'h30) begin
         errors++; $display("FAIL rmid_first got v %b imm %h/%h tag %h want v 1 imm 4 tag 30",
                            vld32, imm32, imm64, tag32);
      end
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_sel    = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      test_reset();
      test_modes();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
